// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle RV32I-subset sequencer with memory wait handshake,
//               memory timeout trap and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [WAIT_W-1:0] c_WAIT_MAX    = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] c_WAIT_ONE    = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  c_INSTRET_ONE = CNT_W'(1);

  localparam logic [3:0] c_FETCH    = 4'd0;
  localparam logic [3:0] c_DECODE   = 4'd1;
  localparam logic [3:0] c_MEMADR   = 4'd2;
  localparam logic [3:0] c_MEMREAD  = 4'd3;
  localparam logic [3:0] c_MEMWB    = 4'd4;
  localparam logic [3:0] c_MEMWRITE = 4'd5;
  localparam logic [3:0] c_EXECR    = 4'd6;
  localparam logic [3:0] c_EXECI    = 4'd7;
  localparam logic [3:0] c_ALUWB    = 4'd8;
  localparam logic [3:0] c_BEQ      = 4'd9;
  localparam logic [3:0] c_JAL      = 4'd10;
  localparam logic [3:0] c_TRAP     = 4'd11;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  logic [3:0]        r_state;
  logic [3:0]        w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_instret;
  logic              r_illegal;
  logic              r_bus_err;

  logic              w_mem_state;
  logic              w_wait_expired;
  logic              w_decode_ok;
  logic [2:0]        w_r_alu;
  logic              w_r_legal;
  logic [2:0]        w_i_alu;
  logic              w_i_legal;
  logic [1:0]        w_imm_src;
  logic              w_set_illegal;
  logic              w_retire;
  logic              w_unused_funct7;

  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign w_mem_state    = (r_state == c_FETCH) || (r_state == c_MEMREAD) ||
                          (r_state == c_MEMWRITE);
  // mem_ready in the final wait cycle takes priority over the timeout
  assign w_wait_expired = w_mem_state && !mem_ready && (r_wait_cnt == c_WAIT_MAX);

  assign w_decode_ok = (op == c_OP_LOAD) || (op == c_OP_STORE) || (op == c_OP_RTYPE) ||
                       (op == c_OP_ITYPE) || (op == c_OP_JAL) ||
                       ((op == c_OP_BRANCH) && (funct3 == 3'b000));

  always_comb begin
    w_r_alu   = c_ALU_AND;
    w_r_legal = 1'b1;
    w_i_alu   = c_ALU_AND;
    w_i_legal = 1'b1;
    case (funct3)
      3'b000: begin
        w_r_alu = funct7[5] ? c_ALU_SUB : c_ALU_ADD;
        w_i_alu = c_ALU_ADD;
      end
      3'b111: begin
        w_r_alu = c_ALU_AND;
        w_i_alu = c_ALU_AND;
      end
      3'b110: begin
        w_r_alu = c_ALU_OR;
        w_i_alu = c_ALU_OR;
      end
      3'b010: begin
        w_r_alu = c_ALU_SLT;
        w_i_alu = c_ALU_SLT;
      end
      default: begin
        w_r_legal = 1'b0;
        w_i_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_imm_src = 2'b00;
    case (op)
      c_OP_STORE:  w_imm_src = 2'b01;
      c_OP_BRANCH: w_imm_src = 2'b10;
      c_OP_JAL:    w_imm_src = 2'b11;
      default:     w_imm_src = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_FETCH: begin
        if (mem_ready)           w_next_state = c_DECODE;
        else if (w_wait_expired) w_next_state = c_TRAP;
      end
      c_DECODE: begin
        case (op)
          c_OP_LOAD,
          c_OP_STORE:  w_next_state = c_MEMADR;
          c_OP_RTYPE:  w_next_state = c_EXECR;
          c_OP_ITYPE:  w_next_state = c_EXECI;
          c_OP_BRANCH: w_next_state = (funct3 == 3'b000) ? c_BEQ : c_TRAP;
          c_OP_JAL:    w_next_state = c_JAL;
          default:     w_next_state = c_TRAP;
        endcase
      end
      c_MEMADR:   w_next_state = (op == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
      c_MEMREAD: begin
        if (mem_ready)           w_next_state = c_MEMWB;
        else if (w_wait_expired) w_next_state = c_TRAP;
      end
      c_MEMWB:    w_next_state = c_FETCH;
      c_MEMWRITE: begin
        if (mem_ready)           w_next_state = c_FETCH;
        else if (w_wait_expired) w_next_state = c_TRAP;
      end
      c_EXECR:    w_next_state = w_r_legal ? c_ALUWB : c_TRAP;
      c_EXECI:    w_next_state = w_i_legal ? c_ALUWB : c_TRAP;
      c_ALUWB:    w_next_state = c_FETCH;
      c_BEQ:      w_next_state = c_FETCH;
      c_JAL:      w_next_state = c_ALUWB;
      c_TRAP:     w_next_state = c_TRAP;
      default:    w_next_state = c_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = c_ALU_AND;
    result_src  = 2'b00;
    imm_src     = w_imm_src;
    case (r_state)
      c_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = c_ALU_ADD;
        result_src  = 2'b10;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      c_DECODE: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b01;
        alu_control = c_ALU_ADD;
      end
      c_MEMADR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = c_ALU_ADD;
      end
      c_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      c_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      c_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      c_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = w_r_alu;
      end
      c_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = w_i_alu;
      end
      c_ALUWB: reg_write = 1'b1;
      c_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = c_ALU_SUB;
        pc_write    = zero;
      end
      c_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_control = c_ALU_ADD;
        pc_write    = 1'b1;
      end
      default: imm_src = 2'b00;
    endcase
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      result_src  = 2'b00;
      imm_src     = 2'b00;
    end
  end

  assign w_set_illegal = ((r_state == c_DECODE) && !w_decode_ok) ||
                         ((r_state == c_EXECR) && !w_r_legal) ||
                         ((r_state == c_EXECI) && !w_i_legal);

  assign w_retire = (r_state == c_MEMWB) || (r_state == c_ALUWB) || (r_state == c_BEQ) ||
                    ((r_state == c_MEMWRITE) && mem_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_instret  <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_mem_state && !mem_ready && !w_wait_expired) begin
        r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_retire) begin
        r_instret <= r_instret + c_INSTRET_ONE;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_wait_expired) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed and randomized checks of multicycle_controller
//               against an instruction-plan reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0]       alu_control;
  logic             illegal, bus_err;
  logic [CNT_W-1:0] instret;

  multicycle_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .result_src(result_src), .imm_src(imm_src), .illegal(illegal), .bus_err(bus_err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // One entry per remaining non-fetch cycle of the current instruction
  typedef struct packed {
    logic       mem;
    logic       mem_write;
    logic       adr_src;
    logic       pc_write;
    logic       pcw_zero;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
    logic [1:0] rs;
    logic       trap;
    logic       retire;
  } step_t;

  step_t plan[$];
  logic  m_trapped;
  logic  m_ill;
  logic  m_berr;
  int    m_wcnt;
  int    m_instret;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int alu_rule(input logic is_r, input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'b000:  return (is_r && f7b5) ? 6 : 2;
      3'b111:  return 0;
      3'b110:  return 1;
      3'b010:  return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic [1:0] imm_rule(input logic [6:0] o);
    if (o == OP_STORE)  return 2'b01;
    if (o == OP_BRANCH) return 2'b10;
    if (o == OP_JAL)    return 2'b11;
    return 2'b00;
  endfunction

  task automatic m_reset();
    plan.delete();
    m_trapped = 1'b0;
    m_ill     = 1'b0;
    m_berr    = 1'b0;
    m_wcnt    = 0;
    m_instret = 0;
  endtask

  task automatic build_plan();
    step_t s;
    step_t wb;
    int    r;
    plan.delete();
    wb = '0; wb.reg_write = 1'b1; wb.retire = 1'b1;
    s = '0; s.a = 2'b01; s.b = 2'b01; s.alu = 3'b010;
    if (op == OP_LOAD || op == OP_STORE) begin
      plan.push_back(s);
      s = '0; s.a = 2'b10; s.b = 2'b01; s.alu = 3'b010;
      plan.push_back(s);
      s = '0; s.mem = 1'b1; s.adr_src = 1'b1;
      if (op == OP_STORE) begin
        s.mem_write = 1'b1; s.retire = 1'b1;
        plan.push_back(s);
      end else begin
        plan.push_back(s);
        s = '0; s.rs = 2'b01; s.reg_write = 1'b1; s.retire = 1'b1;
        plan.push_back(s);
      end
    end else if (op == OP_RTYPE || op == OP_ITYPE) begin
      plan.push_back(s);
      r = alu_rule(op == OP_RTYPE, funct3, funct7[5]);
      s = '0; s.a = 2'b10; s.b = (op == OP_ITYPE) ? 2'b01 : 2'b00;
      if (r < 0) begin
        s.trap = 1'b1;
        plan.push_back(s);
      end else begin
        s.alu = 3'(r);
        plan.push_back(s);
        plan.push_back(wb);
      end
    end else if (op == OP_BRANCH && funct3 == 3'b000) begin
      plan.push_back(s);
      s = '0; s.a = 2'b10; s.alu = 3'b110; s.pcw_zero = 1'b1; s.retire = 1'b1;
      plan.push_back(s);
    end else if (op == OP_JAL) begin
      plan.push_back(s);
      s = '0; s.a = 2'b01; s.b = 2'b10; s.alu = 3'b010; s.pc_write = 1'b1;
      plan.push_back(s);
      plan.push_back(wb);
    end else begin
      s.trap = 1'b1;
      plan.push_back(s);
    end
  endtask

  task automatic mem_wait();
    if (m_wcnt == TIMEOUT - 1) begin
      m_trapped = 1'b1;
      m_berr    = 1'b1;
      m_wcnt    = 0;
      plan.delete();
    end else begin
      m_wcnt++;
    end
  endtask

  task automatic compare();
    step_t       h;
    logic        iw, pw;
    logic [1:0]  imm;
    logic [16:0] e_vec, a_vec;
    h = '0; iw = 1'b0; pw = 1'b0; imm = 2'b00;
    if (rst_n && !m_trapped) begin
      imm = imm_rule(op);
      if (plan.size() == 0) begin
        h.mem = 1'b1; h.b = 2'b10; h.alu = 3'b010; h.rs = 2'b10;
        iw = mem_ready; pw = mem_ready;
      end else begin
        h  = plan[0];
        pw = h.pcw_zero ? zero : h.pc_write;
      end
    end
    e_vec = {h.mem, h.mem_write, h.adr_src, iw, pw, h.reg_write, h.a, h.b, h.alu, h.rs, imm};
    a_vec = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_control, result_src, imm_src};
    chk("ctrl", 32'(a_vec), 32'(e_vec));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("bus_err", 32'(bus_err), 32'(m_berr));
    chk("instret", 32'(instret), 32'(m_instret));
  endtask

  task automatic apply(input logic rn, input logic rdy, input logic z);
    rst_n = rn; mem_ready = rdy; zero = z;
    #2;
    compare();
  endtask

  task automatic advance();
    step_t h;
    if (!rst_n) begin
      m_reset();
    end else if (!m_trapped) begin
      if (plan.size() == 0) begin
        if (mem_ready) begin
          build_plan();
          m_wcnt = 0;
        end else begin
          mem_wait();
        end
      end else begin
        h = plan[0];
        if (h.mem && !mem_ready) begin
          mem_wait();
        end else begin
          void'(plan.pop_front());
          m_wcnt = 0;
          if (h.retire) m_instret = (m_instret + 1) % (1 << CNT_W);
          if (h.trap) begin
            m_trapped = 1'b1;
            m_ill     = 1'b1;
            plan.delete();
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rn, input logic rdy, input logic z);
    apply(rn, rdy, z);
    advance();
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op = o; funct3 = f3; funct7 = f7;
  endtask

  task automatic rand_instr();
    int          k;
    logic [2:0]  legal_f3[4];
    logic [31:0] rv;
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b111; legal_f3[2] = 3'b110; legal_f3[3] = 3'b010;
    k  = int'($urandom_range(0, 15));
    rv = $urandom;
    funct7 = rv[6:0];
    if (k <= 2)       begin op = OP_LOAD;   funct3 = 3'b010; end
    else if (k <= 4)  begin op = OP_STORE;  funct3 = 3'b010; end
    else if (k <= 7)  begin op = OP_RTYPE;  funct3 = legal_f3[$urandom_range(0, 3)]; end
    else if (k <= 10) begin op = OP_ITYPE;  funct3 = legal_f3[$urandom_range(0, 3)]; end
    else if (k <= 12) begin op = OP_BRANCH; funct3 = 3'b000; end
    else if (k <= 14) begin op = OP_JAL;    funct3 = rv[9:7]; end
    else              begin op = rv[16:10]; funct3 = rv[19:17]; end
    if ($urandom_range(0, 9) == 0) funct3 = rv[22:20];
  endtask

  initial begin
    int stall_left;
    int trap_age;
    int lens[5];
    lens[0] = 3; lens[1] = 14; lens[2] = 15; lens[3] = 16; lens[4] = 20;

    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    set_instr(OP_LOAD, 3'b010, 7'd0);
    @(posedge clk);
    #1;
    m_reset();

    // Reset state
    apply(1'b0, 1'b1, 1'b0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_instret", 32'(instret), 0);
    advance();

    // lw with zero wait: write-back only in the fifth cycle
    for (int c = 1; c <= 5; c++) begin
      apply(1'b1, 1'b1, 1'b0);
      chk("lw_reg_write", 32'(reg_write), (c == 5) ? 1 : 0);
      if (c == 5) chk("lw_result_src", 32'(result_src), 32'h1);
      advance();
    end
    apply(1'b1, 1'b0, 1'b0);
    chk("lw_instret", 32'(instret), 1);
    advance();

    // sub then or
    set_instr(OP_RTYPE, 3'b000, 7'b0100000);
    for (int c = 1; c <= 4; c++) begin
      apply(1'b1, 1'b1, 1'b0);
      if (c == 3) chk("sub_alu", 32'(alu_control), 32'h6);
      if (c == 4) chk("sub_reg_write", 32'(reg_write), 1);
      advance();
    end
    set_instr(OP_RTYPE, 3'b110, 7'd0);
    for (int c = 1; c <= 4; c++) begin
      apply(1'b1, 1'b1, 1'b0);
      if (c == 3) chk("or_alu", 32'(alu_control), 32'h1);
      advance();
    end

    // beq taken then not taken
    set_instr(OP_BRANCH, 3'b000, 7'd0);
    for (int c = 1; c <= 3; c++) begin
      apply(1'b1, 1'b1, 1'b1);
      if (c == 3) chk("beq_taken_pcw", 32'(pc_write), 1);
      advance();
    end
    for (int c = 1; c <= 3; c++) begin
      apply(1'b1, 1'b1, 1'b0);
      if (c == 1) chk("beq_instret", 32'(instret), 4);
      if (c == 3) chk("beq_not_taken_pcw", 32'(pc_write), 0);
      advance();
    end

    // Fetch stalled three cycles
    for (int c = 1; c <= 3; c++) begin
      apply(1'b1, 1'b0, 1'b0);
      chk("stall_ir_write", 32'(ir_write), 0);
      chk("stall_pc_write", 32'(pc_write), 0);
      advance();
    end
    apply(1'b1, 1'b1, 1'b0);
    chk("ready_ir_write", 32'(ir_write), 1);
    chk("ready_pc_write", 32'(pc_write), 1);
    advance();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("stall_no_bus_err", 32'(bus_err), 0);

    // sw whose ready arrives in the last allowed cycle
    set_instr(OP_STORE, 3'b010, 7'd0);
    for (int c = 1; c <= 3; c++) cyc(1'b1, 1'b1, 1'b0);
    for (int c = 1; c < TIMEOUT; c++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    chk("late_ready_bus_err", 32'(bus_err), 0);
    chk("late_ready_instret", 32'(instret), 7);
    advance();

    // sw whose memory never answers
    for (int c = 1; c <= 3; c++) cyc(1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= TIMEOUT; c++) cyc(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    chk("timeout_bus_err", 32'(bus_err), 1);
    chk("timeout_mem_req", 32'(mem_req), 0);
    advance();
    cyc(1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    chk("post_reset_bus_err", 32'(bus_err), 0);
    chk("post_reset_mem_req", 32'(mem_req), 1);
    advance();

    // Illegal branch funct3
    set_instr(OP_BRANCH, 3'b111, 7'd0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    chk("illegal_flag", 32'(illegal), 1);
    chk("illegal_mem_req", 32'(mem_req), 0);
    advance();
    cyc(1'b0, 1'b1, 1'b0);

    // Sixteen addi retires wrap the 4-bit counter
    set_instr(OP_ITYPE, 3'b000, 7'd0);
    for (int n = 0; n < 16; n++) begin
      apply(1'b1, 1'b1, 1'b0);
      if (n == 15) chk("wrap_pre", 32'(instret), 15);
      advance();
      for (int c = 1; c <= 3; c++) cyc(1'b1, 1'b1, 1'b0);
    end
    apply(1'b1, 1'b0, 1'b0);
    chk("wrap_zero", 32'(instret), 0);
    advance();

    // Randomized traffic
    stall_left = 0;
    trap_age   = 0;
    for (int i = 0; i < 4000; i++) begin
      logic rn, rdy;
      trap_age = m_trapped ? trap_age + 1 : 0;
      rn = !((trap_age > 3) || ($urandom_range(0, 149) == 0));
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 39) == 0) begin
        stall_left = lens[$urandom_range(0, 4)] - 1;
        rdy = 1'b0;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      if (plan.size() == 0 && !m_trapped) rand_instr();
      cyc(rn, rdy, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
